// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame FSM state encoding, parity types and frame-length helper.
// Also used by the edge/bit counter so both sides agree on where the stop bit sits.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // bit_cnt value of the stop bit: start(0), data(1..N), optional parity, stop
  function automatic logic [3:0] stop_bit_idx(input int unsigned data_width, input logic par_en);
    return 4'(data_width + 1) + {3'b000, par_en};
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART frame controller and its counter, sampler and byte consumer.
// master = frame controller, slave = surrounding receiver logic.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
);
  logic                   RX_IN;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [3:0]             bit_cnt;
  logic [PRESC_WIDTH-1:0] edge_cnt;
  logic                   sampled_bit;
  logic                   enable;
  logic                   dat_samp_en;
  logic [DATA_WIDTH-1:0]  P_DATA;
  logic                   data_valid;
  logic                   par_err;
  logic                   stp_err;
  logic                   strt_glitch;

  modport master (
    input  RX_IN, PAR_EN, PAR_TYP, prescale, bit_cnt, edge_cnt, sampled_bit,
    output enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
  );

  modport slave (
    output RX_IN, PAR_EN, PAR_TYP, prescale, bit_cnt, edge_cnt, sampled_bit,
    input  enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
  );
endinterface

// File: rtl/uart_rx_deser.sv
// Deserializer for the UART receiver: indexed bit writes into a data word, plus its XOR parity.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [3:0]            wr_idx,
  input  logic                  wr_bit,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  parity
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      word <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (wr_idx == 4'(i)) word[i] <= wr_bit;
      end
    end
  end

  assign parity = ^word;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, counter enable, start/parity/stop checks,
// and delivery of each error-free byte with a single-cycle data_valid.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_frame_ctrl_if.master bus
);

  rx_state_e             state, state_nxt;
  logic                  cfg_par_en, cfg_par_typ;
  logic                  par_err_q, stp_err_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  last_edge;
  logic [3:0]            stop_idx;
  logic                  data_idx_ok;
  logic                  start_entry, wr_en, par_chk, stp_chk, glitch;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_par;

  assign last_edge   = (bus.edge_cnt == (bus.prescale - PRESC_WIDTH'(1)));
  assign stop_idx    = stop_bit_idx(DATA_WIDTH, cfg_par_en);
  assign data_idx_ok = (bus.bit_cnt != 4'd0) && (bus.bit_cnt <= 4'(DATA_WIDTH));

  uart_rx_deser #(.DATA_WIDTH(DATA_WIDTH)) u_deser (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (wr_en),
    .wr_idx (bus.bit_cnt - 4'd1),
    .wr_bit (bus.sampled_bit),
    .word   (word),
    .parity (word_par)
  );

  // Counter values that do not match the current state are ignored: only LE with the expected bit_cnt acts
  always_comb begin
    state_nxt   = state;
    start_entry = 1'b0;
    wr_en       = 1'b0;
    par_chk     = 1'b0;
    stp_chk     = 1'b0;
    glitch      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.RX_IN) begin
          state_nxt   = ST_START;
          start_entry = 1'b1;
        end
      end
      ST_START: begin
        if (last_edge && bus.bit_cnt == 4'd0) begin
          if (!bus.sampled_bit) begin
            state_nxt = ST_DATA;
          end else begin
            glitch    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (last_edge && data_idx_ok) begin
          wr_en = 1'b1;
          if (bus.bit_cnt == 4'(DATA_WIDTH)) state_nxt = cfg_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (last_edge && bus.bit_cnt == 4'(DATA_WIDTH + 1)) begin
          par_chk   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_edge && bus.bit_cnt == stop_idx) begin
          stp_chk   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.RX_IN) begin
          state_nxt   = ST_START;
          start_entry = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= PAR_EVEN;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      p_data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (start_entry) begin
        cfg_par_en  <= bus.PAR_EN;
        cfg_par_typ <= bus.PAR_TYP;
        par_err_q   <= 1'b0;
        stp_err_q   <= 1'b0;
      end
      if (par_chk) par_err_q <= (bus.sampled_bit != (word_par ^ cfg_par_typ));
      if (stp_chk) stp_err_q <= ~bus.sampled_bit;
      if (state == ST_DONE && !par_err_q && !stp_err_q) p_data_q <= word;
    end
  end

  assign bus.enable      = (state == ST_START) || (state == ST_DATA) ||
                           (state == ST_PARITY) || (state == ST_STOP);
  assign bus.dat_samp_en = bus.enable;
  assign bus.data_valid  = (state == ST_DONE) && !par_err_q && !stp_err_q;
  assign bus.P_DATA      = p_data_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;
  assign bus.strt_glitch = glitch;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: drives serial frames through a counter/sampler stand-in and
// compares every cycle against a frame-timing model derived from the bit positions.
module tb_uart_rx_frame_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST;

  uart_rx_frame_ctrl_if #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) bus ();

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int P        = 8;
  int t0       = 0;
  int dv_count = 0;
  int last_dv_cyc = -1;
  int last_gl_cyc = -1;
  logic noise = 1'b0;
  logic fr_par_en = 1'b0;
  logic chk_on = 1'b0;

  // counter / sampler stand-in
  logic [3:0]    cnt_bit;
  logic [PW-1:0] cnt_edge;

  always @(posedge CLK) begin
    if (RST || !bus.enable) begin
      cnt_bit  <= 4'd0;
      cnt_edge <= '0;
    end else if (cnt_edge == PW'(P - 1)) begin
      cnt_edge <= '0;
      cnt_bit  <= (cnt_bit == 4'(DW + 1) + {3'b000, fr_par_en}) ? 4'd0 : cnt_bit + 4'd1;
    end else begin
      cnt_edge <= cnt_edge + PW'(1);
    end
  end

  assign bus.bit_cnt     = cnt_bit;
  assign bus.edge_cnt    = cnt_edge;
  assign bus.prescale    = PW'(P);
  assign bus.sampled_bit = (cnt_edge == PW'(P - 1)) ? bus.RX_IN : noise;

  // expected outputs
  logic         exp_en = 1'b0, exp_dv = 1'b0, exp_gl = 1'b0, exp_par = 1'b0, exp_stp = 1'b0;
  logic [DW-1:0] exp_pdata = '0;
  logic          done_pend = 1'b0, done_good = 1'b0, done_stp = 1'b0;
  logic [DW-1:0] done_data = '0;
  logic          pdata_pend = 1'b0;
  logic [DW-1:0] pdata_nxt = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      cmp("enable",      32'(bus.enable),      32'(exp_en));
      cmp("dat_samp_en", 32'(bus.dat_samp_en), 32'(exp_en));
      cmp("data_valid",  32'(bus.data_valid),  32'(exp_dv));
      cmp("strt_glitch", 32'(bus.strt_glitch), 32'(exp_gl));
      cmp("par_err",     32'(bus.par_err),     32'(exp_par));
      cmp("stp_err",     32'(bus.stp_err),     32'(exp_stp));
      cmp("P_DATA",      32'(bus.P_DATA),      32'(exp_pdata));
      if (bus.data_valid === 1'b1) begin
        dv_count++;
        last_dv_cyc = cyc;
      end
      if (bus.strt_glitch === 1'b1) last_gl_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Per-cycle bookkeeping: P_DATA shows a good byte the cycle after DONE
  task automatic begin_cycle();
    exp_dv = 1'b0;
    exp_gl = 1'b0;
    if (pdata_pend) begin
      exp_pdata  = pdata_nxt;
      pdata_pend = 1'b0;
    end
    if (done_pend) begin
      exp_en  = 1'b0;
      exp_stp = done_stp;
      if (done_good) begin
        exp_dv     = 1'b1;
        pdata_nxt  = done_data;
        pdata_pend = 1'b1;
      end
      done_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      begin_cycle();
      bus.RX_IN = 1'b1;
      exp_en    = 1'b0;
      noise     = 1'($urandom);
      tick();
    end
  endtask

  // One frame from its first low cycle (n=0). Bit k is on the line for cycles k*p+1..(k+1)*p,
  // the start bit from cycle 0. glitch_len>0 makes a false start; rst_at>=0 aborts with RST.
  task automatic frame(input int p, input logic [DW-1:0] data, input logic pbit, input logic sbit,
                       input logic pen, input logic ptyp, input int glitch_len, input int rst_at,
                       input bit b2b);
    int   s, l, lastn, k;
    logic par_e, stp_e, line;
    P         = p;
    t0        = cyc;
    fr_par_en = pen;
    s     = DW + 1 + int'(pen);
    l     = (s + 1) * p + 1;
    lastn = (glitch_len > 0) ? p : l - 1;
    par_e = pen && (pbit != ((^data) ^ ptyp));
    stp_e = !sbit;
    for (int n = 0; n <= lastn; n++) begin
      begin_cycle();
      if (glitch_len > 0)  line = (n < glitch_len) ? 1'b0 : 1'b1;
      else if (n <= p)     line = 1'b0;
      else begin
        k = (n - 1) / p;
        if (k <= DW)                   line = data[k-1];
        else if (pen && k == DW + 1)   line = pbit;
        else                           line = sbit;
      end
      bus.RX_IN   = line;
      bus.PAR_EN  = (n == 0) ? pen  : 1'($urandom);
      bus.PAR_TYP = (n == 0) ? ptyp : 1'($urandom);
      noise       = 1'($urandom);
      exp_en      = (n >= 1);
      if (n == 1) begin
        exp_par = 1'b0;
        exp_stp = 1'b0;
      end
      if (glitch_len > 0 && n == p) exp_gl = 1'b1;
      if (glitch_len == 0 && pen && n == (DW + 2) * p + 1) exp_par = par_e;
      if (n == rst_at) RST = 1'b1;
      tick();
      if (n == rst_at) begin
        RST        = 1'b0;
        exp_en     = 1'b0;
        exp_dv     = 1'b0;
        exp_gl     = 1'b0;
        exp_par    = 1'b0;
        exp_stp    = 1'b0;
        exp_pdata  = '0;
        pdata_pend = 1'b0;
        done_pend  = 1'b0;
        bus.RX_IN  = 1'b1;
        return;
      end
    end
    if (glitch_len == 0) begin
      done_pend = 1'b1;
      done_good = !par_e && !stp_e;
      done_stp  = stp_e;
      done_data = data;
      if (!b2b) begin
        begin_cycle();
        bus.RX_IN = 1'b1;
        exp_en    = 1'b0;
        noise     = 1'($urandom);
        tick();
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int dv0, p, gl;
    logic [DW-1:0] d;
    logic pen, ptyp, pb, sb;
    bit b2b;
    RST         = 1'b1;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    RST = 1'b0;
    idle(3);

    // 8N1, 0xA5
    dv0 = dv_count;
    frame(8, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 0);
    cmp("s1_dv_cycle", 32'(last_dv_cyc - t0), 32'd81);
    cmp("s1_dv_count", 32'(dv_count - dv0), 32'd1);
    idle(2);
    cmp("s1_pdata", 32'(bus.P_DATA), 32'h0A5);

    // prescale 16, even parity, 0x3C good then bad parity
    dv0 = dv_count;
    frame(16, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1, 0);
    cmp("s2_dv_cycle", 32'(last_dv_cyc - t0), 32'd177);
    idle(1);
    cmp("s2_pdata", 32'(bus.P_DATA), 32'h03C);
    dv0 = dv_count;
    frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, 0);
    idle(1);
    cmp("s2_par_err", 32'(bus.par_err), 32'd1);
    cmp("s2_no_dv", 32'(dv_count - dv0), 32'd0);
    cmp("s2_pdata_kept", 32'(bus.P_DATA), 32'h03C);

    // false start
    dv0 = dv_count;
    frame(8, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2, -1, 0);
    cmp("s3_glitch_cycle", 32'(last_gl_cyc - t0), 32'd8);
    idle(2);
    cmp("s3_no_dv", 32'(dv_count - dv0), 32'd0);
    cmp("s3_enable", 32'(bus.enable), 32'd0);

    // stop error then good frame
    dv0 = dv_count;
    frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 0);
    cmp("s4_stp_err", 32'(bus.stp_err), 32'd1);
    cmp("s4_no_dv", 32'(dv_count - dv0), 32'd0);
    frame(8, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 0);
    idle(1);
    cmp("s4_pdata", 32'(bus.P_DATA), 32'h081);
    cmp("s4_stp_clear", 32'(bus.stp_err), 32'd0);

    // back-to-back at prescale 32
    dv0 = dv_count;
    frame(32, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 1);
    frame(32, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 0);
    idle(1);
    cmp("s5_dv_count", 32'(dv_count - dv0), 32'd2);
    cmp("s5_dv_cycle", 32'(last_dv_cyc - t0), 32'd321);
    cmp("s5_pdata", 32'(bus.P_DATA), 32'h000);

    // reset mid-frame then recovery
    dv0 = dv_count;
    frame(8, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 0, 40, 0);
    idle(3);
    cmp("s6_no_dv", 32'(dv_count - dv0), 32'd0);
    frame(8, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 0);
    idle(1);
    cmp("s6_pdata", 32'(bus.P_DATA), 32'h011);

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      p    = 8 << $urandom_range(0, 2);
      d    = DW'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pb   = ((^d) ^ ptyp) ^ ($urandom_range(0, 4) == 0);
      sb   = ($urandom_range(0, 5) != 0);
      gl   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p - 1) : 0;
      b2b  = (gl == 0) && ($urandom_range(0, 2) == 0);
      frame(p, d, pb, sb, pen, ptyp, gl, -1, b2b);
      if (!b2b) idle($urandom_range(0, 3));
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller for the UART receiver. It detects the start edge on RX_IN and drives the edge/bit counter through its enable. It consumes bit_cnt/edge_cnt from the counter and sampled_bit from the data sampler, then deserializes data, checks start/parity/stop, and emits the received byte with a one-cycle data_valid pulse. It sits between the counter/sampler and the receiver's parallel-data consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..8; bit_cnt is 4 bits)
PRESC_WIDTH, 6, width of prescale and edge_cnt

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset: synchronous, active-high
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
prescale  in  PRESC_WIDTH  oversampling ratio; legal values 8, 16, 32
bit_cnt  in  4  from counter: 0 = start, 1..DATA_WIDTH = data, then parity (if enabled), then stop
edge_cnt  in  PRESC_WIDTH  from counter: 0..prescale-1 within the current bit
sampled_bit  in  1  sampler majority result, stable by edge_cnt == prescale-1
enable  out  1  counter enable
dat_samp_en  out  1  sampler enable, equal to enable
P_DATA  out  DATA_WIDTH  last good byte
data_valid  out  1  one-cycle pulse when P_DATA updates
par_err  out  1  parity error for the current/last frame
stp_err  out  1  stop error for the current/last frame
strt_glitch  out  1  one-cycle pulse on a false start

Behaviour:
- Clock/reset: one clock, CLK. RST is synchronous and active-high. At RST: state IDLE; enable, dat_samp_en, data_valid, par_err, stp_err, strt_glitch = 0; P_DATA = 0; shift register = 0. An RST mid-frame abandons the frame with no data_valid pulse.
- "Last edge" (LE) means edge_cnt == prescale-1.
- enable is a Moore output: 1 only in START, DATA, PARITY, STOP.
- IDLE: when RX_IN == 0, latch PAR_EN/PAR_TYP into frame config and go to START. Changes to PAR_EN/PAR_TYP mid-frame are ignored.
- On entry to START: clear par_err and stp_err.
- START, at LE with bit_cnt == 0:
  - sampled_bit == 0: go to DATA.
  - otherwise: strt_glitch = 1 for one cycle, go to IDLE. Counter clears because enable drops.
- DATA, at LE: write sampled_bit into shift register bit (bit_cnt-1), LSB first. When bit_cnt == DATA_WIDTH: go to PARITY if latched PAR_EN, else STOP.
- PARITY, at LE: expected = XOR of shift register, inverted if PAR_TYP == 1. Set par_err = (sampled_bit != expected). Always go to STOP.
- STOP, at LE: set stp_err = (sampled_bit != 1). Go to DONE.
- DONE (exactly one cycle, enable = 0):
  - No errors: data_valid = 1 this cycle and P_DATA <= shift register.
  - Any error: data_valid stays 0 and P_DATA is unchanged.
  - Next state: START if RX_IN == 0 (back-to-back frame, clears errors on entry), else IDLE.
- Counter alignment: the counter wraps bit_cnt/edge_cnt to 0 at the stop-bit LE, and enable = 0 in DONE/IDLE holds them at 0. START therefore always begins at edge_cnt = 0.
- Latency (prescale = P, the IDLE cycle that sees RX_IN = 0 is cycle 0):
  - DONE/data_valid at cycle (DATA_WIDTH+2)*P + 1.
  - Add P when parity is enabled.
- data_valid never asserts on two consecutive cycles.
- par_err/stp_err hold their value until the next START entry or RST.
- Inconsistent counter inputs: a bit_cnt/edge_cnt value not matching the current state is ignored; the FSM only acts on LE with the expected bit_cnt.

Decomposition:
- Shared package uart_rx_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP, DONE; 3-bit).
  - PAR_EVEN/PAR_ODD constants.
  - Frame-length helper: stop bit index = DATA_WIDTH+1+PAR_EN.
  These constants are shared with the edge/bit counter.
- One natural sub-module, uart_rx_deser: shift register plus parity computation (write strobe, index, bit in → word out, parity out).
- The FSM and checks stay in the top level.

Test Plan:
- prescale = 8, PAR_EN = 0, byte 0xA5, stop = 1 → data_valid pulses once at cycle 81; P_DATA = 0xA5; par_err = stp_err = 0.
- prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit 0 → data_valid at cycle 177, P_DATA = 0x3C. Repeat with parity bit 1 → par_err = 1, no data_valid, P_DATA keeps its old value.
- prescale = 8, RX_IN low for 2 cycles then high → strt_glitch pulses at cycle 8, enable returns to 0, no data_valid, FSM back in IDLE.
- prescale = 8, byte 0x5A with stop bit 0 → stp_err = 1, no data_valid. Next good frame 0x81 → errors clear on START, data_valid, P_DATA = 0x81.
- prescale = 32, two back-to-back frames 0xFF then 0x00 with RX_IN low in the DONE cycle → both delivered, and the second START begins with edge_cnt = 0.
- Assert RST at cycle 40 of a prescale = 8 frame → next cycle all outputs 0, state IDLE, no data_valid. A subsequent frame 0x11 is received correctly.
